scara_move_sequencer: RTL and testbench

Command queue and sequencer for the two SCARA joint stepper drivers. Accepts coordinated two-joint move commands over a valid/ready interface and buffers them in a small FIFO. Each move is loaded into both stepper drivers with the driver's 200 ns setup/hold margins met, and the block waits for both joints to report finished before issuing a one-cycle completion pulse. It sits between the motion-planning logic and the pair of stepper driver instances, which share the `new_in` and `fast` lines.

---
 rtl/scara_move_sequencer.sv | 125 ++++++++++++
 tb/tb_scara_move_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scara_move_sequencer.sv
// scara_move_sequencer: queues two-joint move commands and sequences each one into both stepper drivers
module scara_move_sequencer #(
   parameter int DEPTH     = 4,
   parameter int SETUP_CYC = 10,
   parameter int PULSE_CYC = 10
) (
   input  logic                     clk_50,
   input  logic                     reset_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [7:0]               cmd_steps_a,
   input  logic [7:0]               cmd_steps_b,
   input  logic                     cmd_dir_a,
   input  logic                     cmd_dir_b,
   input  logic                     cmd_fast,
   input  logic                     abort,
   input  logic                     fin_a,
   input  logic                     fin_b,
   output logic [7:0]               steps_a,
   output logic [7:0]               steps_b,
   output logic                     dir_a,
   output logic                     dir_b,
   output logic                     fast,
   output logic                     new_in,
   output logic                     motor_en,
   output logic                     busy,
   output logic                     move_done,
   output logic [$clog2(DEPTH):0]   queue_count
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int TMAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETUP  = 3'd1;
   localparam logic [2:0] PULSE  = 3'd2;
   localparam logic [2:0] SETTLE = 3'd3;
   localparam logic [2:0] RUN    = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;
   logic [2:0]    state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] timer;
   logic [18:0]   mem [DEPTH];
   logic          push;
   logic          pop;
   assign cmd_ready   = count < CW'(DEPTH);
   assign queue_count = count;
   assign busy        = state != IDLE;
   assign push        = cmd_valid & cmd_ready;
   assign pop         = (state == IDLE) && (count != '0);
   always_ff @(posedge clk_50) begin
      if (push)
         mem[wr_ptr] <= {cmd_fast, cmd_dir_b, cmd_dir_a, cmd_steps_b, cmd_steps_a};
   end
   always_ff @(posedge clk_50) begin
      if (!reset_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         timer     <= '0;
         steps_a   <= '0;
         steps_b   <= '0;
         dir_a     <= 1'b0;
         dir_b     <= 1'b0;
         fast      <= 1'b0;
         new_in    <= 1'b0;
         motor_en  <= 1'b0;
         move_done <= 1'b0;
      end else if (abort) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         timer     <= '0;
         new_in    <= 1'b0;
         motor_en  <= 1'b0;
         move_done <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count     <= count + CW'(push) - CW'(pop);
         move_done <= 1'b0;
         case (state)
            IDLE: if (pop) begin
               {fast, dir_b, dir_a, steps_b, steps_a} <= mem[rd_ptr];
               state    <= SETUP;
               timer    <= '0;
               motor_en <= 1'b1;
            end
            // one extra setup cycle puts the new_in rise 12 cycles after the push
            SETUP: if (timer == TW'(SETUP_CYC)) begin
               state  <= PULSE;
               new_in <= 1'b1;
               timer  <= '0;
            end else
               timer <= timer + 1'b1;
            PULSE: if (timer == TW'(PULSE_CYC - 1)) begin
               state  <= SETTLE;
               new_in <= 1'b0;
               timer  <= '0;
            end else
               timer <= timer + 1'b1;
            SETTLE: if (timer == TW'(1)) begin
               state <= RUN;
               timer <= '0;
            end else
               timer <= timer + 1'b1;
            RUN: if (fin_a & fin_b) begin
               state     <= DONE;
               move_done <= 1'b1;
            end
            DONE: begin
               state    <= IDLE;
               motor_en <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_scara_move_sequencer.sv
// tb_scara_move_sequencer: directed checks of queueing, move timing, zero-step, abort and reset
module tb_scara_move_sequencer;
   logic       clk_50 = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_steps_a = '0;
   logic [7:0] cmd_steps_b = '0;
   logic       cmd_dir_a = 1'b0;
   logic       cmd_dir_b = 1'b0;
   logic       cmd_fast = 1'b0;
   logic       abort = 1'b0;
   logic       fin_a;
   logic       fin_b;
   logic [7:0] steps_a;
   logic [7:0] steps_b;
   logic       dir_a;
   logic       dir_b;
   logic       fast;
   logic       new_in;
   logic       motor_en;
   logic       busy;
   logic       move_done;
   logic [2:0] queue_count;
   logic [7:0] rem_a;
   logic [7:0] rem_b;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_pass = 0;
   int         done_cnt = 0;
   int         last_done = 0;
   int         last_fall = 0;
   logic       prev_ni = 1'b0;
   int         rise_q[$];
   logic [15:0] ab_q[$];

   scara_move_sequencer dut (
      .clk_50(clk_50), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_steps_a(cmd_steps_a), .cmd_steps_b(cmd_steps_b), .cmd_dir_a(cmd_dir_a),
      .cmd_dir_b(cmd_dir_b), .cmd_fast(cmd_fast), .abort(abort), .fin_a(fin_a), .fin_b(fin_b),
      .steps_a(steps_a), .steps_b(steps_b), .dir_a(dir_a), .dir_b(dir_b), .fast(fast),
      .new_in(new_in), .motor_en(motor_en), .busy(busy), .move_done(move_done),
      .queue_count(queue_count)
   );

   always #10 clk_50 = ~clk_50;
   always @(posedge clk_50) cyc <= cyc + 1;

   // joint driver model: latch while new_in high, then one step per cycle
   always @(posedge clk_50) begin
      if (!reset_n) begin
         rem_a <= '0;
         rem_b <= '0;
      end else if (new_in) begin
         rem_a <= steps_a;
         rem_b <= steps_b;
      end else begin
         if (rem_a != 0) rem_a <= rem_a - 1'b1;
         if (rem_b != 0) rem_b <= rem_b - 1'b1;
      end
   end
   assign fin_a = !new_in && rem_a == 0;
   assign fin_b = !new_in && rem_b == 0;

   always begin
      @(posedge clk_50);
      #1;
      if (new_in && !prev_ni) begin
         rise_q.push_back(cyc);
         ab_q.push_back({steps_a, steps_b});
      end
      if (!new_in && prev_ni) last_fall = cyc;
      if (move_done) begin
         done_cnt++;
         last_done = cyc;
      end
      prev_ni = new_in;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic da, input logic db,
                       input logic f, output int pc);
      int w = 0;
      cmd_steps_a = a;
      cmd_steps_b = b;
      cmd_dir_a = da;
      cmd_dir_b = db;
      cmd_fast = f;
      cmd_valid = 1'b1;
      while (!cmd_ready && w < 400) begin
         @(negedge clk_50);
         w++;
      end
      if (!cmd_ready) check("push_timeout", 0, 1);
      @(negedge clk_50);
      pc = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int w = 0;
      while (done_cnt < target && w < budget) begin
         @(negedge clk_50);
         w++;
      end
      check("done_wait", done_cnt, target);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, p0, p5, base, dbase, rbase;
      logic [7:0] qa[6] = '{8'd2, 8'd3, 8'd0, 8'd1, 8'd6, 8'd7};
      logic [7:0] qb[6] = '{8'd1, 8'd0, 8'd4, 8'd1, 8'd2, 8'd7};
      repeat (3) @(negedge clk_50);
      reset_n = 1'b1;
      @(negedge clk_50);
      check("rst_steps_a", steps_a, 0);
      check("rst_new_in", new_in, 0);
      check("rst_motor_en", motor_en, 0);
      check("rst_busy", busy, 0);
      check("rst_qcount", queue_count, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_done", move_done, 0);

      push(8'd5, 8'd3, 1'b1, 1'b0, 1'b1, p);
      wait_done(1, 100);
      check("single_rise", rise_q[0] - p, 12);
      check("single_width", last_fall - rise_q[0], 10);
      check("single_done", last_done - p, 28);
      check("single_steps_a", steps_a, 5);
      check("single_steps_b", steps_b, 3);
      check("single_dir_a", dir_a, 1);
      check("single_dir_b", dir_b, 0);
      check("single_fast", fast, 1);
      @(negedge clk_50);
      check("single_motor_off", motor_en, 0);
      check("single_idle", busy, 0);
      check("single_done_once", done_cnt, 1);

      push(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, p);
      wait_done(2, 100);
      check("zero_done", last_done - last_fall, 3);

      base = ab_q.size();
      dbase = done_cnt;
      push(qa[0], qb[0], 1'b0, 1'b1, 1'b0, p0);
      repeat (2) @(negedge clk_50);
      for (int i = 1; i < 5; i++) push(qa[i], qb[i], i[0], 1'b0, 1'b1, p);
      check("full_count", queue_count, 4);
      check("full_ready", cmd_ready, 0);
      push(qa[5], qb[5], 1'b1, 1'b1, 1'b0, p5);
      check("held_push", p5 - p0, 28);
      wait_done(dbase + 6, 600);
      check("held_vs_rise", p5, rise_q[base + 1] - 10);
      for (int i = 0; i < 6; i++) check($sformatf("order%0d", i), ab_q[base + i], {qa[i], qb[i]});

      base = ab_q.size();
      dbase = done_cnt;
      push(8'd1, 8'd1, 1'b0, 1'b0, 1'b0, p);
      push(8'd4, 8'd2, 1'b0, 1'b0, 1'b0, p);
      check("pushpop_count", queue_count, 1);
      wait_done(dbase + 2, 200);
      check("wrap_first", ab_q[base], {8'd1, 8'd1});
      check("wrap_second", ab_q[base + 1], {8'd4, 8'd2});

      rbase = rise_q.size();
      dbase = done_cnt;
      push(8'd20, 8'd20, 1'b0, 1'b0, 1'b0, p);
      push(8'd1, 8'd1, 1'b0, 1'b0, 1'b0, p);
      push(8'd2, 8'd2, 1'b0, 1'b0, 1'b0, p);
      repeat (30) @(negedge clk_50);
      check("abort_pre_busy", busy, 1);
      check("abort_pre_count", queue_count, 2);
      cmd_steps_a = 8'd9;
      cmd_steps_b = 8'd9;
      cmd_valid = 1'b1;
      abort = 1'b1;
      @(negedge clk_50);
      abort = 1'b0;
      cmd_valid = 1'b0;
      check("abort_motor", motor_en, 0);
      check("abort_busy", busy, 0);
      check("abort_count", queue_count, 0);
      check("abort_new_in", new_in, 0);
      repeat (40) @(negedge clk_50);
      check("abort_no_done", done_cnt, dbase);
      check("abort_no_move", rise_q.size(), rbase + 1);
      check("abort_dropped", queue_count, 0);

      push(8'd3, 8'd3, 1'b1, 1'b1, 1'b1, p);
      repeat (13) @(negedge clk_50);
      check("midrst_pulse", new_in, 1);
      reset_n = 1'b0;
      @(negedge clk_50);
      check("midrst_new_in", new_in, 0);
      check("midrst_busy", busy, 0);
      check("midrst_steps", steps_a, 0);
      check("midrst_motor", motor_en, 0);
      reset_n = 1'b1;
      @(negedge clk_50);
      check("midrst_ready", cmd_ready, 1);
      check("midrst_count", queue_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
